// File: rtl/peridot_servo_pkg.sv
// peridot_servo_pkg: shared constants, register map and FSM states for the servo slew feeder.
package peridot_servo_pkg;
  localparam int FRAME_HZ = 50;
  localparam int STEPCOUNTNUM = 256;
  localparam int UNITFREQ = FRAME_HZ * STEPCOUNTNUM;
  localparam int MAX_CHANNEL = 30;
  localparam logic [4:0] REG_CTRL = 5'd0;
  localparam logic [4:0] REG_RATE = 5'd1;
  localparam logic [4:0] REG_CH0 = 5'd2;
  typedef enum logic [2:0] {ST_IDLE, ST_CTRLWR, ST_CALC, ST_WRITE, ST_NEXT} state_e;
  function automatic int frame_cycles(input int clockfreq);
    return clockfreq / FRAME_HZ;
  endfunction
endpackage

// File: rtl/peridot_servo_slewstep.sv
// peridot_servo_slewstep: moves cur toward tgt by at most rate (0 = jump), flags a change.
module peridot_servo_slewstep (
  input  logic [7:0] cur_i,
  input  logic [7:0] tgt_i,
  input  logic [7:0] rate_i,
  output logic [7:0] nxt_o,
  output logic       chg_o
);
  logic signed [8:0] diff;
  logic [8:0] mag;
  assign diff = $signed({1'b0, tgt_i}) - $signed({1'b0, cur_i});
  assign mag = diff[8] ? 9'(-diff) : 9'(diff);
  assign nxt_o = (rate_i == 8'd0 || mag <= {1'b0, rate_i}) ? tgt_i : diff[8] ? cur_i - rate_i : cur_i + rate_i;
  assign chg_o = nxt_o != cur_i;
endmodule

// File: rtl/peridot_servo_slewctrl.sv
// peridot_servo_slewctrl: CPU-facing target registers, per-frame slewing and push to the servo controller.
module peridot_servo_slewctrl
  import peridot_servo_pkg::*;
#(
  parameter int CHANNEL = 30,
  parameter int CLOCKFREQ = 25000000,
  parameter logic [7:0] INIT_POS = 8'h80
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [4:0]  avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest
);
  localparam int FRAME = frame_cycles(CLOCKFREQ);
  localparam int CW = FRAME > 1 ? $clog2(FRAME) : 1;
  localparam int CHW = CHANNEL > 1 ? $clog2(CHANNEL) : 1;
  localparam logic [5:0] CH_END = 6'(CHANNEL + 2);

  logic [CW-1:0] cnt_q;
  logic [CHW-1:0] ch_q, wch;
  logic [7:0] cur_q [CHANNEL];
  logic [7:0] tgt_q [CHANNEL];
  logic [CHANNEL-1:0] dirty_q;
  logic [7:0] rate_q, rd8, step_nxt;
  logic ena_q, ovr_q, pend_on_q, pend_off_q, step_chg, tick, ch_hit, ctrl_wr, ch_wr;
  logic [23:0] unused_wdata;
  state_e state_q;

  assign unused_wdata = avs_writedata[31:8];
  assign tick = cnt_q == CW'(FRAME - 1);
  assign wch = CHW'(avs_address - REG_CH0);
  assign ch_hit = avs_address >= REG_CH0 && {1'b0, avs_address} < CH_END;
  assign ctrl_wr = avs_write && avs_address == REG_CTRL;
  assign ch_wr = avs_write && ch_hit;

  always_comb begin
    rd8 = avs_address == REG_CTRL ? {5'b0, ovr_q, state_q != ST_IDLE, ena_q} :
          avs_address == REG_RATE ? rate_q : ch_hit ? cur_q[wch] : 8'h00;
  end

  peridot_servo_slewstep u_step (
    .cur_i (cur_q[ch_q]),
    .tgt_i (tgt_q[ch_q]),
    .rate_i(rate_q),
    .nxt_o (step_nxt),
    .chg_o (step_chg)
  );

  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      cnt_q <= '0;
      ena_q <= 1'b0;
      rate_q <= '0;
      avs_readdata <= '0;
      for (int i = 0; i < CHANNEL; i++) tgt_q[i] <= INIT_POS;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (avs_read) avs_readdata <= {24'b0, rd8};
      if (ctrl_wr) ena_q <= avs_writedata[0];
      if (avs_write && avs_address == REG_RATE) rate_q <= avs_writedata[7:0];
      if (ch_wr) tgt_q[wch] <= avs_writedata[7:0];
    end
  end

  // CPU-side flag sets are placed after the FSM so they win over same-cycle clears
  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      state_q <= ST_IDLE;
      ch_q <= '0;
      ovr_q <= 1'b0;
      pend_on_q <= 1'b0;
      pend_off_q <= 1'b0;
      dirty_q <= '1;
      for (int i = 0; i < CHANNEL; i++) cur_q[i] <= INIT_POS;
      avm_write <= 1'b0;
      avm_address <= '0;
      avm_writedata <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (tick && (ena_q || pend_off_q)) begin
          ch_q <= '0;
          if (pend_on_q || pend_off_q) begin
            state_q <= ST_CTRLWR;
            avm_write <= 1'b1;
            avm_address <= REG_CTRL;
            avm_writedata <= {31'b0, ena_q};
          end else state_q <= ST_CALC;
        end
        ST_CTRLWR: if (!avm_waitrequest) begin
          avm_write <= 1'b0;
          pend_on_q <= 1'b0;
          pend_off_q <= 1'b0;
          state_q <= ena_q ? ST_CALC : ST_IDLE;
        end
        ST_CALC: begin
          cur_q[ch_q] <= step_nxt;
          if (step_chg || dirty_q[ch_q]) begin
            dirty_q[ch_q] <= 1'b0;
            state_q <= ST_WRITE;
            avm_write <= 1'b1;
            avm_address <= 5'(ch_q) + REG_CH0;
            avm_writedata <= {24'b0, step_nxt};
          end else state_q <= ST_NEXT;
        end
        ST_WRITE: if (!avm_waitrequest) begin
          avm_write <= 1'b0;
          state_q <= ST_NEXT;
        end
        ST_NEXT: if (ch_q == CHW'(CHANNEL - 1)) state_q <= ST_IDLE;
          else begin
            ch_q <= ch_q + 1'b1;
            state_q <= ST_CALC;
          end
        default: state_q <= ST_IDLE;
      endcase
      if (ctrl_wr) begin
        if (avs_writedata[2]) ovr_q <= 1'b0;
        if (avs_writedata[0] && !ena_q) begin
          pend_on_q <= 1'b1;
          dirty_q <= '1;
        end
        if (!avs_writedata[0] && ena_q) pend_off_q <= 1'b1;
      end
      if (ch_wr) dirty_q[wch] <= 1'b1;
      if (tick && state_q != ST_IDLE) ovr_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_peridot_servo_slewctrl.sv
// tb_peridot_servo_slewctrl: frame-level reference model feeding a scoreboard of expected servo writes.
module tb_peridot_servo_slewctrl;
  localparam int CH = 4;
  localparam int FR = 1280;

  logic clk = 0, rst_n = 0;
  logic [4:0] avs_address = 0, avm_address;
  logic avs_read = 0, avs_write = 0, avm_write, avm_waitrequest = 0;
  logic [31:0] avs_readdata, avs_writedata = 0, avm_writedata;

  always #5 clk = ~clk;

  peridot_servo_slewctrl #(.CHANNEL(CH), .CLOCKFREQ(64000), .INIT_POS(8'h80)) dut (
    .csi_clk(clk), .rsi_reset_n(rst_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest)
  );

  int checks = 0, failures = 0;
  logic [36:0] exp_q[$];
  logic [36:0] e;
  int m_cur[CH], m_tgt[CH], m_rate, fcnt;
  bit m_dirty[CH];
  bit m_ena, m_pend_on, m_pend_off, m_ovr, busy_hint, force_stall, rand_stall;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic int slew(int c, int t, int r);
    if (r == 0) return t;
    if (t > c) return (c + r < t) ? c + r : t;
    return (c - r > t) ? c - r : t;
  endfunction

  function automatic logic [7:0] ctrl_exp();
    return {5'b0, m_ovr, 1'b0, m_ena};
  endfunction

  task automatic model_reset();
    m_ena = 0; m_pend_on = 0; m_pend_off = 0; m_ovr = 0; m_rate = 0;
    for (int i = 0; i < CH; i++) begin m_cur[i] = 128; m_tgt[i] = 128; m_dirty[i] = 1; end
    exp_q.delete();
  endtask

  task automatic model_tick();
    int n;
    if (busy_hint) begin m_ovr = 1; return; end
    if (!(m_ena || m_pend_off)) return;
    if (m_pend_on || m_pend_off) begin
      exp_q.push_back({5'd0, 32'(m_ena)});
      m_pend_on = 0; m_pend_off = 0;
    end
    if (m_ena) for (int i = 0; i < CH; i++) begin
      n = slew(m_cur[i], m_tgt[i], m_rate);
      if (n != m_cur[i] || m_dirty[i]) exp_q.push_back({5'(i + 2), 32'(n)});
      m_dirty[i] = 0;
      m_cur[i] = n;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin fcnt = 0; model_reset(); end
    else begin
      if (fcnt == FR - 1) model_tick();
      fcnt = (fcnt == FR - 1) ? 0 : fcnt + 1;
    end
  end

  always @(posedge clk) begin
    #2;
    avm_waitrequest = (force_stall && avm_address != 0) || (rand_stall && $urandom_range(0, 3) == 0);
  end

  bit prev_stall = 0;
  logic [4:0] prev_a;
  logic [31:0] prev_d;
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("stall_write_held", {31'b0, avm_write}, 32'd1);
        check("stall_addr_stable", {27'b0, avm_address}, {27'b0, prev_a});
        check("stall_data_stable", avm_writedata, prev_d);
      end
      if (avm_write && !avm_waitrequest) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write got addr=%0d data=%h want none", avm_address, avm_writedata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {27'b0, avm_address}, {27'b0, e[36:32]});
          check("wr_data", avm_writedata, e[31:0]);
        end
      end
      prev_stall = avm_write && avm_waitrequest;
      prev_a = avm_address;
      prev_d = avm_writedata;
    end
  end

  task automatic wait_pos(int p);
    int n = 0;
    do begin @(negedge clk); n++; end while (fcnt != p && n < 3 * FR);
    if (fcnt != p) check("wait_pos_timeout", fcnt, p);
  endtask

  task automatic wait_write();
    int n = 0;
    while (!(avm_write && avm_address != 0) && n < 3 * FR) begin @(negedge clk); n++; end
    if (!(avm_write && avm_address != 0)) check("wait_write_timeout", {31'b0, avm_write}, 32'd1);
  endtask

  task automatic wr(logic [4:0] a, logic [7:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = {24'b0, d}; avs_write = 1;
    if (a == 0) begin
      if (d[0] && !m_ena) begin m_pend_on = 1; for (int i = 0; i < CH; i++) m_dirty[i] = 1; end
      if (!d[0] && m_ena) m_pend_off = 1;
      m_ena = d[0];
      if (d[2]) m_ovr = 0;
    end else if (a == 1) m_rate = d;
    else if (a < CH + 2) begin m_tgt[a - 2] = d; m_dirty[a - 2] = 1; end
    @(negedge clk);
    avs_write = 0;
  endtask

  task automatic rd(logic [4:0] a, logic [7:0] exp, string nm);
    @(negedge clk);
    avs_address = a; avs_read = 1;
    @(negedge clk);
    avs_read = 0;
    check(nm, avs_readdata, {24'b0, exp});
  endtask

  task automatic check_reset_state();
    check("rst_avm_write", {31'b0, avm_write}, 32'd0);
    check("rst_avm_addr", {27'b0, avm_address}, 32'd0);
    check("rst_avm_data", avm_writedata, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    rd(0, 8'h00, "rst_ctrl");
    rd(1, 8'h00, "rst_rate");
    for (int i = 0; i < CH; i++) rd(5'(i + 2), 8'h80, "rst_cur");
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_reset_state();
    wr(0, 8'h01);
    repeat (2) wait_pos(600);
    wr(1, 8'h10); wr(2, 8'hC0);
    repeat (5) begin wait_pos(600); rd(2, 8'(m_cur[0]), "slew_cur0"); end
    wr(1, 8'h30); wr(3, 8'h20);
    repeat (3) begin wait_pos(600); rd(3, 8'(m_cur[1]), "clamp_cur1"); end
    wr(4, 8'h10);
    wait_pos(FR - 10); force_stall = 1;
    wait_write();
    repeat (100) @(negedge clk);
    force_stall = 0;
    wait_pos(600);
    rd(4, 8'(m_cur[2]), "stall_cur2");
    wr(5, 8'h00);
    wait_pos(FR - 10); force_stall = 1;
    wait_pos(FR - 10); busy_hint = 1;
    wait_pos(10); busy_hint = 0; force_stall = 0;
    wait_pos(600);
    rd(0, ctrl_exp(), "ovr_set");
    wr(0, 8'h05);
    rd(0, ctrl_exp(), "ovr_clear");
    rand_stall = 1;
    for (int f = 0; f < 16; f++) begin
      int c;
      wait_pos(600);
      if ($urandom_range(0, 2) == 0) wr(1, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(1, 3)) wr(5'($urandom_range(2, CH + 1)), 8'($urandom));
      if ($urandom_range(0, 5) == 0) wr(0, 8'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) wr(5'($urandom_range(CH + 2, 31)), 8'($urandom));
      rd(0, ctrl_exp(), "rnd_ctrl");
      c = $urandom_range(0, CH - 1);
      rd(5'(c + 2), 8'(m_cur[c]), "rnd_cur");
      rd(5'($urandom_range(CH + 2, 31)), 8'h00, "rnd_unmapped");
    end
    rand_stall = 0;
    wr(0, 8'h01);
    wait_pos(600);
    wr(0, 8'h00);
    wait_pos(600);
    rd(0, ctrl_exp(), "ena_off_ctrl");
    wr(0, 8'h01);
    wait_pos(FR - 10); force_stall = 1;
    wait_write();
    repeat (3) @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1; force_stall = 0;
    @(negedge clk);
    check_reset_state();
    repeat (2) wait_pos(600);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/peridot_servo_slewctrl.md
Name: peridot_servo_slewctrl

Overview:
- Upstream feeder for the PERIDOT RC servo controller: per-channel target positions written by CPU; current position is slewed toward target by at most RATE steps per 20 ms frame.
- Each frame, changed channel values are pushed to the servo controller through an Avalon-MM master, one word write per channel.
- Sits between the CPU Avalon-MM bus (slave side) and the servo controller's register slave (master side, point-to-point).

Parameters:
- CHANNEL, 30, number of slewed channels, 1-30; maps to servo registers 2..CHANNEL+1.
- CLOCKFREQ, 25000000, csi_clk frequency in Hz; frame period = CLOCKFREQ/50 cycles.
- INIT_POS, 8'h80, reset value of every current/target position.

Ports:
- csi_clk  in  1  sole clock, all logic on rising edge.
- rsi_reset_n  in  1  synchronous, active-low reset.
- avs_address  in  5  slave word address.
- avs_read  in  1  read strobe; readdata valid next cycle (0-setup,1-wait,0-hold).
- avs_readdata  out  32  {24'b0, data8}.
- avs_write  in  1  write strobe, zero wait.
- avs_writedata  in  32  bits [7:0] used.
- avm_address  out  5  servo register word index.
- avm_write  out  1  master write request.
- avm_writedata  out  32  {24'b0, value8}.
- avm_waitrequest  in  1  servo stall; write is accepted on a cycle with avm_write=1 and waitrequest=0.

Behaviour:
- Reset (rsi_reset_n=0 at a clock edge): ENA=0, RATE=0, OVR=0, all cur/tgt=INIT_POS, all dirty=1, frame counter=0, FSM=IDLE, avm_write=0, avm_address=0, avm_writedata=0, avs_readdata=0. Reset mid-transfer drops the write at that edge; no completion.
- Register map:
  - 0: CTRL. bit0 ENA (R/W), bit1 BUSY (RO, FSM!=IDLE), bit2 OVR (sticky; write 1 clears).
  - 1: RATE, 8-bit; 0 means jump immediately.
  - 2..CHANNEL+1: write sets tgt[n] and dirty[n]; read returns cur[n].
  - Other addresses read 0; writes are ignored.
- Frame tick: one-cycle pulse when the counter wraps at CLOCKFREQ/50-1. The counter always runs.
- ENA edge handling:
  - ENA 0->1 sets pend_on and all dirty bits.
  - ENA 1->0 sets pend_off.
  - Both are serviced at the next tick, regardless of ENA for pend_off.
- FSM states:
  - IDLE: on tick with (ENA or pend_off) go to CTRLWR if a pend flag is set, else go to CALC with ch=0. Tick while not IDLE sets OVR; that tick is dropped.
  - CTRLWR: drive addr 0, data {31'b0,ENA}; hold until accepted; clear the pend flag. If ENA=0 go to IDLE, else go to CALC with ch=0.
  - CALC (1 cycle): sample tgt[ch].
    - diff = tgt-cur as a 9-bit signed value.
    - If RATE==0 or |diff|<=RATE: cur<=tgt. Otherwise cur<=cur±RATE.
    - No wrap, since the result never passes tgt.
    - If the result differs from the old cur, or dirty[ch]=1: clear dirty and go to WRITE. Otherwise go to NEXT.
  - WRITE: avm_address=ch+2, avm_writedata=cur[ch]; avm_write held high with address/data stable until waitrequest=0, then go to NEXT.
  - NEXT: if ch==CHANNEL-1 go to IDLE, else ch+1 and go to CALC.
- Simultaneous events:
  - CPU write to tgt[ch] in the same cycle as CALC of ch: CALC uses the old tgt; new value and dirty take effect next frame.
  - CPU write to a channel already scanned this frame: sets dirty for next frame.
  - CTRL write clearing OVR in the same cycle as an overrun: set wins.

Decomposition:
- Shared package peridot_servo_pkg: STEPCOUNTNUM, UNITFREQ, FRAME_HZ=50, register indices (REG_CTRL=0, REG_RATE=1, REG_CH0=2), MAX_CHANNEL=30.
- One sub-module, peridot_servo_slewstep: combinational cur/tgt/rate -> next cur plus changed flag.

Test Plan:
- Reset, ENA=1, no target writes, CLOCKFREQ=64000 (frame 1280 cycles), CHANNEL=4 -> at first tick one CTRLWR (addr0, data1), then writes addr2..5 data 0x80 each; second frame has no writes.
- RATE=0x10, tgt[0]=0xC0 -> successive frames write addr2 with 0x90, 0xA0, 0xB0, 0xC0, then no further writes; read addr2 returns the matching cur.
- RATE=0x30, tgt[1]=0x20 from 0x80 -> writes 0x50 then 0x20 (clamp, no undershoot).
- avm_waitrequest held high 100 cycles during WRITE -> avm_write/address/data stable throughout; single acceptance; next channel proceeds.
- Waitrequest held beyond one frame -> OVR=1 and that tick is dropped; write 1 to CTRL bit2 -> OVR reads 0.
- ENA 1->0 mid-frame, then rsi_reset_n low during a WRITE -> next tick gives a single write addr0 data0; after reset, avm_write=0 and all reads return reset values.
